// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: FSM state encoding, coin-select
// encodings and the default parameter values used by the top level.
package change_dispenser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_GAP      = 3'd3,
    ST_DONE     = 3'd4,
    ST_FAULT    = 3'd5
  } state_e;

  localparam logic COIN_SEL_HI = 1'b1;
  localparam logic COIN_SEL_LO = 1'b0;

  localparam int DEF_AMT_W       = 3;
  localparam int DEF_COIN_HI     = 2;
  localparam int DEF_ACK_TIMEOUT = 15;
  localparam int DEF_GAP_CYC     = 1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/change_dispenser_timer.sv
// Up-counter with synchronous clear and enable; term_o flags that the count
// has reached last_i. Shared by the ack-timeout and inter-coin gap phases.
module change_dispenser_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] last_i,
  output logic             term_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign term_o = (count_q == last_i);

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount as greedy HI/LO coins over a req/ack handshake with
// the coin hopper, with ack timeout and empty-tube fault handling.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int AMT_W       = DEF_AMT_W,
  parameter int COIN_HI     = DEF_COIN_HI,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int GAP_CYC     = DEF_GAP_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chg_valid,
  input  logic [AMT_W-1:0] chg_amt,
  output logic             chg_ready,
  output logic             coin_req,
  output logic             coin_sel,
  input  logic             coin_ack,
  input  logic             hi_empty,
  input  logic             lo_empty,
  output logic [AMT_W-1:0] remaining,
  output logic             done,
  output logic             fault,
  input  logic             fault_clr
);

  localparam int TMR_W = $clog2(max2(ACK_TIMEOUT, GAP_CYC) + 1);
  localparam logic [TMR_W-1:0] ACK_LAST = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYC - 1);
  localparam logic [AMT_W-1:0] HI_VAL   = AMT_W'(COIN_HI);
  localparam logic [AMT_W-1:0] LO_VAL   = AMT_W'(1);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic             coin_req_q, coin_req_d;
  logic             coin_sel_q, coin_sel_d;
  logic             fault_q, fault_d;
  logic             done_q, done_d;
  logic             chg_ready_q, chg_ready_d;

  logic             tmr_clr, tmr_en, tmr_term;
  logic [TMR_W-1:0] tmr_last;

  // One counter serves both waiting phases; its terminal value follows the state.
  assign tmr_last = (state_q == ST_GAP) ? GAP_LAST : ACK_LAST;

  change_dispenser_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .last_i (tmr_last),
    .term_o (tmr_term)
  );

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    coin_req_d  = coin_req_q;
    coin_sel_d  = coin_sel_q;
    fault_d     = fault_q;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    // The pulse is raised as the FSM leaves DONE, two cycles after acceptance.
    done_d      = (state_q == ST_DONE);

    unique case (state_q)
      ST_IDLE: begin
        if (chg_valid) begin
          remaining_d = chg_amt;
          state_d     = (chg_amt != '0) ? ST_SELECT : ST_DONE;
        end
      end

      ST_SELECT: begin
        if (remaining_q >= HI_VAL && !hi_empty) begin
          coin_sel_d = COIN_SEL_HI;
          coin_req_d = 1'b1;
          tmr_clr    = 1'b1;
          state_d    = ST_WAIT_ACK;
        end else if (remaining_q != '0 && !lo_empty) begin
          coin_sel_d = COIN_SEL_LO;
          coin_req_d = 1'b1;
          tmr_clr    = 1'b1;
          state_d    = ST_WAIT_ACK;
        end else begin
          fault_d = 1'b1;
          state_d = ST_FAULT;
        end
      end

      ST_WAIT_ACK: begin
        // A late ack arriving on the timeout cycle still counts as a paid coin.
        if (coin_ack) begin
          remaining_d = remaining_q - ((coin_sel_q == COIN_SEL_HI) ? HI_VAL : LO_VAL);
          coin_req_d  = 1'b0;
          tmr_clr     = 1'b1;
          state_d     = ST_GAP;
        end else if (tmr_term) begin
          coin_req_d = 1'b0;
          fault_d    = 1'b1;
          state_d    = ST_FAULT;
        end else begin
          tmr_en = 1'b1;
        end
      end

      ST_GAP: begin
        if (tmr_term) begin
          state_d = (remaining_q == '0) ? ST_DONE : ST_SELECT;
        end else begin
          tmr_en = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      ST_FAULT: begin
        if (fault_clr) begin
          remaining_d = '0;
          fault_d     = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    chg_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      coin_req_q  <= 1'b0;
      coin_sel_q  <= 1'b0;
      fault_q     <= 1'b0;
      done_q      <= 1'b0;
      chg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      coin_req_q  <= coin_req_d;
      coin_sel_q  <= coin_sel_d;
      fault_q     <= fault_d;
      done_q      <= done_d;
      chg_ready_q <= chg_ready_d;
    end
  end

  assign chg_ready = chg_ready_q;
  assign coin_req  = coin_req_q;
  assign coin_sel  = coin_sel_q;
  assign remaining = remaining_q;
  assign done      = done_q;
  assign fault     = fault_q;

endmodule
